pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the team's single-cycle 32-bit logical-left shifter.
- Width N is generic. Supports four shift modes: SLL, SRL, SRA and ROL.
- One log-stage per 2^k shift, each registered, with a valid/ready handshake on both sides.
- Sits between the ALU operand mux and the writeback register; gives multi-cycle, full-throughput shifting at wide N without a long combinational path.

Parameters:
- N, 32, data width; must be a power of two, 8..128.
- S, $clog2(N), number of pipeline stages and shamt width; derived, not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_shamt/in_mode are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  N  operand to shift.
- in_shamt  input  S  shift amount, 0..N-1.
- in_mode  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROL (rotate left).
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  N  shifted result.

Behaviour:
- Reset: when rst is high at a clock edge, all stage valid bits clear.
  - out_valid=0 and out_data=0 after the edge.
  - in_ready=1 in the cycle following reset.
  - Reset mid-operation discards all in-flight results; no partial output appears.
- Pipeline structure:
  - Stage k (k=0..S-1) holds registers: valid_k, data_k, shamt_k, mode_k.
  - Stage k applies a 2^k shift when shamt bit k=1, otherwise passes data through.
  - Stage 0 operates on in_data; the final stage register drives out_data/out_valid.
- Stage-k shift by mode:
  - SLL: shift left, fill zeros.
  - SRL: shift right, fill zeros.
  - SRA: shift right, fill with in_data[N-1]. The sign bit is carried with the operand, so it stays correct across stages.
  - ROL: bits shifted out of the MSB re-enter at the LSB.
- Advance rule: adv = !out_valid || out_ready.
  - When adv=1, every stage loads from its predecessor; stage 0 loads {in_valid, in_data, in_shamt, in_mode}.
  - When adv=0, all stage registers hold.
  - in_ready = adv (combinational from out_valid and out_ready).
- Handshakes:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_valid low while adv=1 inserts a bubble (valid=0). Bubbles are not collapsed; they advance like data.
- Latency and throughput:
  - Exactly S cycles from input transfer to out_valid, absent stalls: N=32 gives 5 cycles.
  - Throughput is 1 result per cycle with out_ready held high.
- Ordering: results emerge strictly in input order; no reordering, no dropping.
- Stall: out_valid=1 with out_ready=0 freezes the whole pipeline. out_data must remain stable until it is accepted.
- Simultaneous events: out_valid=1, out_ready=1 and in_valid=1 in the same cycle causes a transfer on both sides, and the pipeline shifts by one.
- Boundaries:
  - shamt=0 returns in_data unchanged in all modes.
  - shamt=N-1 is the maximum; no out-of-range values exist since the width is S.
  - in_mode=11 with shamt=0 returns the input unchanged.
- Data registers may load while valid=0, but out_data must read 0 whenever out_valid=0 after reset until the first valid result; gate on valid.

Test Plan:
- Reset: assert rst 2 cycles with pipeline full -> out_valid=0 next cycle, out_data=0, in_ready=1; nothing emitted for 5 cycles after release with in_valid=0.
- Single op per mode, N=32, in_data=0x8000_00F1, shamt=4 -> after exactly 5 cycles:
  - SLL gives 0x0000_0F10.
  - SRL gives 0x0800_000F.
  - SRA gives 0xF800_000F.
  - ROL gives 0x0000_0F18.
- Streaming: 64 back-to-back random ops (all modes, shamt 0..31), out_ready=1 -> 64 results in order, one per cycle starting cycle 5, each matching a reference model.
- Backpressure: stream with out_ready toggled pseudo-randomly (50%) -> in_ready tracks adv; out_data stable while out_valid && !out_ready; no loss or duplication vs. model.
- Edge amounts: in_data=0xFFFF_FFFF with shamt=0 and shamt=31 in each mode:
  - shamt=0 gives 0xFFFF_FFFF in all modes.
  - SLL gives 0x8000_0000 at 31.
  - SRL gives 0x0000_0001 at 31.
  - SRA gives 0xFFFF_FFFF at 31.
  - ROL gives 0xFFFF_FFFF at 31.
- Mid-stream reset plus parameter sweep: assert rst with 3 ops in flight -> those 3 never appear. Re-run the single-op test at N=8 and N=64 with S=3 and 6 cycles of latency respectively.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Purpose:
//   Log-structured barrel shifter with one registered stage per power-of-two
//   shift distance. Stage k shifts by 2^k when bit k of the shift amount is
//   set. Supports SLL, SRL, SRA and ROL at full throughput with S = log2(N)
//   cycles of latency.
//
// Ports:
//   i_clk        system clock, all state on the rising edge
//   i_rst        synchronous, active-high reset
//   i_in_valid   operand/shamt/mode are valid this cycle
//   o_in_ready   block accepts an input this cycle
//   i_in_data    operand to shift (N bits)
//   i_in_shamt   shift amount 0..N-1 (S bits)
//   i_in_mode    00=SLL, 01=SRL, 10=SRA, 11=ROL
//   o_out_valid  o_out_data holds a completed result
//   i_out_ready  downstream accepts o_out_data this cycle
//   o_out_data   shifted result, forced to zero while o_out_valid is low
//
// Handshake: an input transfer happens on a rising edge where
// i_in_valid && o_in_ready; an output transfer happens where
// o_out_valid && i_out_ready. The whole pipe moves together
// (adv = !o_out_valid || i_out_ready); when it does not move every stage
// holds, so o_out_data is stable until accepted. Bubbles are not collapsed.
// ---------------------------------------------------------------------------
module pipelined_barrel_shifter #(
    parameter  int N = 32,
    localparam int S = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [N-1:0] i_in_data,
    input  logic [S-1:0] i_in_shamt,
    input  logic [1:0]   i_in_mode,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [N-1:0] o_out_data
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    // Per-stage registers
    logic         r_valid [S];
    logic [N-1:0] r_data  [S];
    logic [S-1:0] r_shamt [S];
    logic [1:0]   r_mode  [S];
    logic         r_sign  [S];

    // Stage inputs (stage 0 from the ports, stage k from stage k-1)
    logic         w_src_valid [S];
    logic [N-1:0] w_src_data  [S];
    logic [S-1:0] w_src_shamt [S];
    logic [1:0]   w_src_mode  [S];
    logic         w_src_sign  [S];
    logic [N-1:0] w_next_data [S];

    logic         w_adv;
    logic         w_unused;

    // One stage of the shifter: conditional shift by a fixed distance.
    function automatic logic [N-1:0] f_stage(
        input logic [N-1:0] d,
        input logic         en,
        input logic [1:0]   mode,
        input logic         sgn,
        input int           sh
    );
        logic [N-1:0] res;
        logic [N-1:0] ones;
        ones = '1;
        res  = d;
        if (en) begin
            case (mode)
                MODE_SLL: res = d << sh;
                MODE_SRL: res = d >> sh;
                // Fill comes from the operand's original MSB, carried down
                // the pipe, not from the partially shifted value.
                MODE_SRA: res = (d >> sh) | (sgn ? ~(ones >> sh) : '0);
                MODE_ROL: res = (d << sh) | (d >> (N - sh));
                default:  res = d;
            endcase
        end
        return res;
    endfunction

    assign w_adv       = !r_valid[S-1] || i_out_ready;
    assign o_in_ready  = w_adv;
    assign o_out_valid = r_valid[S-1];
    assign o_out_data  = r_valid[S-1] ? r_data[S-1] : '0;

    // The last stage has no successor to consume its control fields.
    assign w_unused = ^{r_shamt[S-1], r_mode[S-1], r_sign[S-1]};

    always_comb begin
        w_src_valid[0] = i_in_valid;
        w_src_data[0]  = i_in_data;
        w_src_shamt[0] = i_in_shamt;
        w_src_mode[0]  = i_in_mode;
        w_src_sign[0]  = i_in_data[N-1];
        for (int k = 1; k < S; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_data[k]  = r_data[k-1];
            w_src_shamt[k] = r_shamt[k-1];
            w_src_mode[k]  = r_mode[k-1];
            w_src_sign[k]  = r_sign[k-1];
        end
        for (int k = 0; k < S; k++) begin
            w_next_data[k] = f_stage(w_src_data[k], w_src_shamt[k][k],
                                     w_src_mode[k], w_src_sign[k], 1 << k);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < S; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_shamt[k] <= '0;
                r_mode[k]  <= 2'b00;
                r_sign[k]  <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < S; k++) begin
                r_valid[k] <= w_src_valid[k];
                r_data[k]  <= w_next_data[k];
                r_shamt[k] <= w_src_shamt[k];
                r_mode[k]  <= w_src_mode[k];
                r_sign[k]  <= w_src_sign[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data  = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_mode  = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;

  // 8-bit instance
  logic        v8 = 1'b0;
  logic        rdy8;
  logic [7:0]  d8 = '0;
  logic [2:0]  s8 = '0;
  logic [1:0]  m8 = '0;
  logic        ov8;
  logic        or8 = 1'b1;
  logic [7:0]  od8;

  // 64-bit instance
  logic        v64 = 1'b0;
  logic        rdy64;
  logic [63:0] d64 = '0;
  logic [5:0]  s64 = '0;
  logic [1:0]  m64 = '0;
  logic        ov64;
  logic        or64 = 1'b1;
  logic [63:0] od64;

  pipelined_barrel_shifter #(.N(32)) dut32 (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .i_in_shamt(in_shamt), .i_in_mode(in_mode),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data)
  );

  pipelined_barrel_shifter #(.N(8)) dut8 (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(v8), .o_in_ready(rdy8), .i_in_data(d8),
    .i_in_shamt(s8), .i_in_mode(m8),
    .o_out_valid(ov8), .i_out_ready(or8), .o_out_data(od8)
  );

  pipelined_barrel_shifter #(.N(64)) dut64 (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(v64), .o_in_ready(rdy64), .i_in_data(d64),
    .i_in_shamt(s64), .i_in_mode(m64),
    .o_out_valid(ov64), .i_out_ready(or64), .o_out_data(od64)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  // Bit-level definition of each mode for an n-bit operand (n <= 128).
  function automatic logic [127:0] ref_model(input logic [127:0] d, input int s,
                                             input logic [1:0] m, input int n);
    logic [127:0] mask;
    logic [127:0] r;
    logic signed [127:0] sx;
    mask = (n == 128) ? '1 : ((128'd1 << n) - 128'd1);
    d = d & mask;
    r = '0;
    case (m)
      2'b00: r = (d << s) & mask;
      2'b01: r = d >> s;
      2'b10: begin
        sx = $signed(d << (128 - n));
        sx = sx >>> (128 - n + s);
        r  = sx & mask;
      end
      default: begin
        for (int i = 0; i < n; i++) r[(i + s) % n] = d[i];
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref32(input logic [31:0] d, input int s, input logic [1:0] m);
    logic [127:0] r;
    r = ref_model({96'd0, d}, s, m, 32);
    return r[31:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Sends one op into an empty 32-bit pipe, returns result and latency (-1 on timeout).
  task automatic drive_one32(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                             output logic [31:0] res, output int lat);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = out_data;
    if (!out_valid) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic drive_one8(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                            output logic [7:0] res, output int lat);
    v8 = 1'b1; d8 = d; s8 = s; m8 = m;
    @(posedge clk); #1;
    v8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = od8;
    if (!ov8) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic drive_one64(input logic [63:0] d, input logic [5:0] s, input logic [1:0] m,
                             output logic [63:0] res, output int lat);
    v64 = 1'b1; d64 = d; s64 = s; m64 = m;
    @(posedge clk); #1;
    v64 = 1'b0;
    lat = 1;
    while (!ov64 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = od64;
    if (!ov64) lat = -1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    // Out of the initial reset
    n_checks++;
    if ({out_valid, out_data, in_ready} !== {1'b0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_init: valid=%0b data=%h ready=%0b, want 0/0/1", out_valid, out_data, in_ready);
    end
    // Fill and stall the pipe, then reset it for two cycles
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom_range(0, 31));
      in_mode = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fill: valid=%0b ready=%0b, want 1/0", out_valid, in_ready);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, out_data, in_ready} !== {1'b0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_full: valid=%0b data=%h ready=%0b, want 0/0/1", out_valid, out_data, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_quiet: cycle %0d valid=%0b data=%h, want 0/0", i, out_valid, out_data);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_mode;
    logic [31:0] exp_tab [4];
    logic [31:0] res;
    int lat;
    exp_tab[0] = 32'h0000_0F10;
    exp_tab[1] = 32'h0800_000F;
    exp_tab[2] = 32'hF800_000F;
    exp_tab[3] = 32'h0000_0F18;
    for (int m = 0; m < 4; m++) begin
      drive_one32(32'h8000_00F1, 5'd4, 2'(m), res, lat);
      n_checks++;
      if (res !== exp_tab[m] || lat !== 5) begin
        n_fail++;
        $display("FAIL single_mode%0d: got %h lat %0d, want %h lat 5", m, res, lat, exp_tab[m]);
      end
    end
  endtask

  task automatic test_edge_amounts;
    logic [31:0] exp31 [4];
    logic [31:0] res;
    int lat;
    exp31[0] = 32'h8000_0000;
    exp31[1] = 32'h0000_0001;
    exp31[2] = 32'hFFFF_FFFF;
    exp31[3] = 32'hFFFF_FFFF;
    for (int m = 0; m < 4; m++) begin
      drive_one32(32'hFFFF_FFFF, 5'd0, 2'(m), res, lat);
      n_checks++;
      if (res !== 32'hFFFF_FFFF || lat !== 5) begin
        n_fail++;
        $display("FAIL edge_sh0_mode%0d: got %h lat %0d, want ffffffff lat 5", m, res, lat);
      end
      drive_one32(32'hFFFF_FFFF, 5'd31, 2'(m), res, lat);
      n_checks++;
      if (res !== exp31[m] || lat !== 5) begin
        n_fail++;
        $display("FAIL edge_sh31_mode%0d: got %h lat %0d, want %h lat 5", m, res, lat, exp31[m]);
      end
    end
    // A few random operands at the extremes, against the model
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      logic [4:0] s;
      d = $urandom;
      s = (i % 2 == 0) ? 5'd0 : 5'd31;
      drive_one32(d, s, 2'(i % 4), res, lat);
      n_checks++;
      if (res !== ref32(d, int'(s), 2'(i % 4))) begin
        n_fail++;
        $display("FAIL edge_rand%0d: got %h want %h", i, res, ref32(d, int'(s), 2'(i % 4)));
      end
    end
  endtask

  task automatic test_back_to_back;
    int sent = 0, got = 0, cyc = 0, first_out = -1, last_out = -1;
    exp_q.delete();
    out_ready = 1'b1;
    while (got < 64 && cyc < 400) begin
      if (sent < 64) begin
        in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom_range(0, 31));
        in_mode = 2'($urandom_range(0, 3));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref32(in_data, int'(in_shamt), in_mode));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: unexpected result %h", out_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL stream_data%0d: got %h want %h", got, out_data, e);
          end
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got !== 64 || first_out !== 5 || last_out !== 68) begin
      n_fail++;
      $display("FAIL stream_timing: got %0d first %0d last %0d, want 64/5/68", got, first_out, last_out);
    end
  endtask

  task automatic test_backpressure;
    int sent = 0, got = 0, cyc = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    exp_q.delete();
    while (got < 80 && cyc < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 80 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom_range(0, 31));
        in_mode = 2'($urandom_range(0, 3));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_fail++;
        $display("FAIL bp_ready: cycle %0d in_ready=%0b valid=%0b out_ready=%0b", cyc, in_ready, out_valid, out_ready);
      end
      if (prev_stall) begin
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, prev_data}) begin
          n_fail++;
          $display("FAIL bp_stable: cycle %0d valid=%0b data=%h, want 1/%h", cyc, out_valid, out_data, prev_data);
        end
      end
      if (!out_valid) begin
        n_checks++;
        if (out_data !== 32'd0) begin
          n_fail++;
          $display("FAIL bp_gate: cycle %0d data=%h while invalid, want 0", cyc, out_data);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref32(in_data, int'(in_shamt), in_mode));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: unexpected result %h", out_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL bp_data%0d: got %h want %h", got, out_data, e);
          end
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got !== 80 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d left %0d, want 80/0", got, exp_q.size());
    end
    wait_cycles(8);
  endtask

  task automatic test_mid_reset;
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = $urandom | 32'h1; in_shamt = 5'($urandom_range(0, 31));
      in_mode = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL mid_reset: %0d results leaked, want 0", seen);
    end
  endtask

  task automatic test_param_sweep;
    logic [7:0] r8;
    logic [63:0] r64;
    logic [127:0] e;
    int lat;
    for (int m = 0; m < 4; m++) begin
      drive_one8(8'hF1, 3'd4, 2'(m), r8, lat);
      e = ref_model({120'd0, 8'hF1}, 4, 2'(m), 8);
      n_checks++;
      if (r8 !== e[7:0] || lat !== 3) begin
        n_fail++;
        $display("FAIL n8_mode%0d: got %h lat %0d, want %h lat 3", m, r8, lat, e[7:0]);
      end
      drive_one64(64'h8000_0000_0000_00F1, 6'd4, 2'(m), r64, lat);
      e = ref_model({64'd0, 64'h8000_0000_0000_00F1}, 4, 2'(m), 64);
      n_checks++;
      if (r64 !== e[63:0] || lat !== 6) begin
        n_fail++;
        $display("FAIL n64_mode%0d: got %h lat %0d, want %h lat 6", m, r64, lat, e[63:0]);
      end
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    test_reset();
    test_single_mode();
    test_edge_amounts();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
